// File: rtl/per_regfile_slave.sv
// per_regfile_slave: register-bank slave on the peripheral request/response channel
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   per_slave_req_i/add_i/we_i/wdata_i/be_i   request channel from the bridge
//   per_slave_gnt_o         combinational grant
//   per_slave_r_valid_o/r_opc_o/r_rdata_o     registered response (opc 1 = bad offset)
//   regs_o                  flattened register contents, reg k on [32k+31:32k]
//   wr_pulse_o              one-cycle strobe per register written
module per_regfile_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int N_REGS     = 8,
  parameter int GNT_WAIT   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   per_slave_req_i,
  input  logic [ADDR_WIDTH-1:0]  per_slave_add_i,
  input  logic                   per_slave_we_i,
  input  logic [31:0]            per_slave_wdata_i,
  input  logic [3:0]             per_slave_be_i,
  output logic                   per_slave_gnt_o,
  output logic                   per_slave_r_valid_o,
  output logic                   per_slave_r_opc_o,
  output logic [31:0]            per_slave_r_rdata_o,
  output logic [32*N_REGS-1:0]   regs_o,
  output logic [N_REGS-1:0]      wr_pulse_o
);
  localparam logic [10:0] NR = 11'(N_REGS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [N_REGS-1:0] r_pulse, w_hit;
  logic [32*N_REGS-1:0] w_regs;
  logic [9:0] w_idx;
  logic [31:0] w_rd, r_rdata;
  logic w_legal, w_gnt, w_wr, r_valid, r_opc;
  // address bits above 11 are already decoded upstream
  logic w_unused_add;
  assign w_unused_add = ^per_slave_add_i[ADDR_WIDTH-1:12];
  assign w_idx = per_slave_add_i[11:2];
  assign w_legal = per_slave_add_i[1:0] == 2'b00 && {1'b0, w_idx} < NR;
  assign w_wr = w_gnt && per_slave_we_i;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    w_gnt = 1'b0;
    case (r_state)
      IDLE: if (per_slave_req_i) begin
        if (GNT_WAIT == 0) begin
          w_gnt = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = 4'(GNT_WAIT - 1);
          w_state_nxt = WAIT;
        end
      end
      // a withdrawn request abandons the wait without grant or response
      WAIT: if (!per_slave_req_i) w_state_nxt = IDLE;
            else if (r_cnt == 4'd0) begin
              w_gnt = 1'b1;
              w_state_nxt = RESP;
            end else w_cnt_nxt = r_cnt - 4'd1;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_opc <= 1'b0;
      r_rdata <= '0;
      r_pulse <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_valid <= w_gnt;
      r_pulse <= w_wr ? w_hit : '0;
      if (w_gnt) begin
        r_opc <= !w_legal;
        r_rdata <= !w_legal ? 32'h0BAD_ACCE : per_slave_we_i ? 32'h0 : w_rd;
      end
    end
  end
  for (genvar k = 0; k < N_REGS; k++) begin : g_reg
    logic [31:0] r_reg;
    assign w_hit[k] = w_legal && w_idx == 10'(k);
    assign w_regs[32*k +: 32] = r_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_reg <= '0;
      else if (w_wr && w_hit[k])
        for (int b = 0; b < 4; b++)
          if (per_slave_be_i[b]) r_reg[8*b +: 8] <= per_slave_wdata_i[8*b +: 8];
    end
  end
  // read mux sees the pre-write value, since registers update on the same edge
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < N_REGS; i++) w_rd |= w_hit[i] ? w_regs[32*i +: 32] : 32'h0;
  end
  assign per_slave_gnt_o = w_gnt;
  assign per_slave_r_valid_o = r_valid;
  assign per_slave_r_opc_o = r_opc;
  assign per_slave_r_rdata_o = r_rdata;
  assign regs_o = w_regs;
  assign wr_pulse_o = r_pulse;
endmodule

// File: doc/per_regfile_slave.md
# per_regfile_slave

Peripheral-interconnect slave that terminates the request/response channel driven by the APB-to-peripheral bridge. It holds a bank of N_REGS 32-bit software registers with byte-enable writes and applies a programmable grant wait-state. It returns one registered response per granted request and flags illegal offsets through the response opcode. It sits directly downstream of the bridge and serves as the register front-end of small peripherals.

## Interface
- ADDR_WIDTH, 32: width of per_slave_add_i.
- N_REGS, 8: number of 32-bit registers; 1..256.
- GNT_WAIT, 0: wait cycles inserted between request and grant; 0..15.
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- per_slave_req_i  input  1  request valid.
- per_slave_add_i  input  ADDR_WIDTH  byte address; only bits [11:0] decoded.
- per_slave_we_i  input  1  1 = write, 0 = read.
- per_slave_wdata_i  input  32  write data.
- per_slave_be_i  input  4  byte enables for writes.
- per_slave_gnt_o  output  1  grant; combinational, request accepted this cycle.
- per_slave_r_valid_o  output  1  response valid, registered.
- per_slave_r_opc_o  output  1  response opcode: 0 = OK, 1 = error.
- per_slave_r_rdata_o  output  32  read data, registered.
- regs_o  output  32*N_REGS  flattened register contents; reg k on [32k+31:32k].
- wr_pulse_o  output  N_REGS  one-cycle strobe per register written.

## Operation
- Decode: offset = add[11:0]. Legal when offset[1:0]==0 and offset[11:2] < N_REGS; index = offset[11:2]. Bits above 11 are ignored because the interconnect has already decoded them.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req and GNT_WAIT==0, assert gnt and go to RESP. If req and GNT_WAIT>0, load wait counter with GNT_WAIT-1 and go to WAIT. With no req, stay in IDLE.
  - WAIT: gnt is 0 while counter>0; counter decrements each cycle. When counter==0 and req is high, assert gnt and go to RESP. If req deasserts at any point in WAIT, return to IDLE with no grant and no response; the master has withdrawn.
  - RESP: r_valid=1 for exactly one cycle, gnt=0, next state IDLE. Requests seen in RESP wait until IDLE. Sustained throughput is one transaction per 2 cycles when GNT_WAIT=0.
- On the grant edge:
  - Legal write: each byte lane with be=1 updates; lanes with be=0 hold. The matching wr_pulse_o bit is 1 in the next cycle only. r_opc=0, rdata=0.
  - Legal read: r_rdata = reg[index] value before any same-cycle update, r_opc=0.
  - Illegal offset, read or write: no register changes, no pulse, r_opc=1, r_rdata=32'h0BAD_ACCE.
- Every granted request, write or read, produces exactly one r_valid. The master may ignore write responses.
- r_rdata_o and r_opc_o hold their last response value between responses.

## Timing
- Reset values: every register 0, regs_o 0, wr_pulse_o 0, gnt 0, r_valid 0, r_opc 0, r_rdata 0, FSM in IDLE, counter 0. Reset asserted mid-transaction aborts it: no response, and no write if reset precedes the grant edge.
- Grant at cycle T+GNT_WAIT for a req raised at T and held. Response at T+GNT_WAIT+1.
- A write granted at T is visible on regs_o at T+1. A read granted at T+2 or later returns the new value.
- The master must hold add, we, wdata and be stable from req until gnt. Values are sampled only on the grant edge.
- gnt_o depends combinationally only on req_i, state and counter. It does not depend on address or data.
- be=4'b0000 on a legal write: no data change, but the pulse and the response are still generated.

## Test plan
- Reset, GNT_WAIT=0 -> all outputs 0. Write 0x0000_0004 data 0xDEADBEEF be=F -> gnt same cycle; reg1=0xDEADBEEF next cycle; wr_pulse_o=8'b0000_0010 for 1 cycle; r_valid one cycle after gnt with r_opc=0.
- Read 0x004 after that write -> r_valid one cycle after gnt, rdata=0xDEADBEEF, opc=0. Read 0x01C after reset -> rdata=0.
- Partial write to reg2 = 0x11223344 with be=F, then write 0xAABBCCDD with be=4'b0101 -> read back 0x11BB33DD.
- Illegal offsets 0x020 (N_REGS=8) and 0x006 -> r_opc=1, rdata=0x0BADACCE, regs_o unchanged, no pulse.
- GNT_WAIT=3: req at cycle 0 -> gnt at cycle 3, r_valid at cycle 4. Req dropped at cycle 2 -> no gnt, no r_valid, FSM back in IDLE.
- Back-to-back: req held high for 4 reads -> grants spaced 2 cycles apart, one r_valid per grant. Reset pulsed in WAIT -> no response, register contents 0.
